// File: rtl/rr_decoder_arbiter_if.sv
// rr_decoder_arbiter_if: request/grant bundle between the requesters and the decoder arbiter.
// Latency: none; this is wiring only.
// Backpressure: none here; the arbiter's grant is the only flow control on the shared decoder.
// Signals: req[7:0]  request vector, bit i = requester i
//          done      current owner releases its grant
//          sel[2:0]  winner index to decoder {x2,x1,x0}
//          en        decoder enable
//          gnt[7:0]  one-hot grant, gnt[sel] = en
//          busy      a grant or its trailing gap cycle is in progress
//          timeout   one-cycle pulse when a grant was revoked by the hold limit
// Modports: master = requester side, slave = arbiter side.
interface rr_decoder_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic [2:0] sel;
  logic       en;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout;

  modport master (
    output req, done,
    input  sel, en, gnt, busy, timeout
  );

  modport slave (
    input  req, done,
    output sel, en, gnt, busy, timeout
  );
endinterface

// File: rtl/rr_decoder_arbiter.sv
// rr_decoder_arbiter: round-robin owner of the shared 3-to-8 enabled decoder among 8 requesters.
// Latency: grant is registered on the edge that samples req in IDLE; release on the edge that samples done.
// Backpressure: the owner keeps the decoder until done / its req drops (or the hold limit); others wait.
// Ports: clk            single clock, rising edge
//        rst_n          asynchronous active-low reset
//        bus (slave)    req[7:0], done in; sel[2:0], en, gnt[7:0], busy, timeout out (all registered)
// Parameter: HOLD_MAX (1..255) maximum grant length, only used when ARB_TIMEOUT_EN is defined.
// Build option: define ARB_TIMEOUT_EN to add the hold counter and revoke grants after HOLD_MAX cycles;
//               without it timeout is tied low and a grant lasts until done or req[sel] drops.
module rr_decoder_arbiter #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_decoder_arbiter_if.slave  bus
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_check
    $error("rr_decoder_arbiter: HOLD_MAX must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic       en_q, en_d;
  logic [7:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;

  logic [2:0] win;
  logic       win_vld;
  logic       exit_rel;   // owner-driven release: done or its own request dropped
  logic       exit_lim;   // hold limit reached this cycle

  // Round-robin scan starting at ptr. Walking the offsets from 7 down to 0
  // lets the lowest offset (closest to ptr) overwrite the others.
  always_comb begin
    logic [2:0] idx;
    idx     = '0;
    win     = ptr_q;
    win_vld = |bus.req;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr_q + 3'(i);
      if (bus.req[idx]) begin
        win = idx;
      end
    end
  end

  assign exit_rel = bus.done || !bus.req[sel_q];

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);

  logic [CW-1:0] hold_cnt_q;
  logic          timeout_q, timeout_d;

  // Counter is 0 in the first GRANT cycle, so matching HOLD_MAX-1 gives
  // exactly HOLD_MAX cycles of en before the revoke.
  assign exit_lim = (hold_cnt_q == CW'(HOLD_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else if (state_q == IDLE && win_vld) begin
      hold_cnt_q <= '0;
    end else if (state_q == GRANT && hold_cnt_q != CW'(HOLD_MAX)) begin
      hold_cnt_q <= hold_cnt_q + CW'(1);
    end
  end

  // Timeout is reported only when the limit is the sole reason for leaving.
  always_comb begin
    timeout_d = (state_q == GRANT) && exit_lim && !exit_rel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign exit_lim    = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld) state_d = GRANT;
      GRANT:   if (exit_rel || exit_lim) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the output registers. sel only moves on
  // the IDLE->GRANT edge, so the decoder index is stable while en is high.
  always_comb begin
    sel_d = sel_q;
    ptr_d = ptr_q;
    if (state_q == IDLE && win_vld) begin
      sel_d = win;
    end
    if (state_q == GRANT && state_d == GAP) begin
      ptr_d = sel_q + 3'd1;
    end
    en_d   = (state_d == GRANT);
    gnt_d  = en_d ? (8'd1 << sel_d) : 8'd0;
    busy_d = (state_d != IDLE);
  end

  assign bus.sel  = sel_q;
  assign bus.en   = en_q;
  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// tb_rr_decoder_arbiter: directed vector bench for rr_decoder_arbiter.
// Each table entry is one clock: inputs driven on the falling edge, outputs
// compared 1 time unit after the rising edge. Reset cases are hand sequences.
module tb_rr_decoder_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rr_decoder_arbiter_if bus ();

  rr_decoder_arbiter #(
    .HOLD_MAX (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Expected outputs packed as {sel[2:0], en, gnt[7:0], busy, timeout}.
  typedef struct {
    string       tag;
    logic [7:0]  req;
    logic        done;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [13:0] pack(logic [2:0] s, logic e, logic [7:0] g, logic b, logic t);
    return {s, e, g, b, t};
  endfunction

  function automatic void add(string tag, logic [7:0] r, logic d,
                              logic [2:0] s, logic e, logic [7:0] g, logic b, logic t);
    vec_t v;
    v.tag  = tag;
    v.req  = r;
    v.done = d;
    v.exp  = pack(s, e, g, b, t);
    vecs.push_back(v);
  endfunction

  function automatic logic [13:0] got();
    return {bus.sel, bus.en, bus.gnt, bus.busy, bus.timeout};
  endfunction

  task automatic check(string tag, logic [13:0] act, logic [13:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got sel=%0d en=%0b gnt=%02h busy=%0b timeout=%0b, expected sel=%0d en=%0b gnt=%02h busy=%0b timeout=%0b",
               tag, act[13:11], act[10], act[9:2], act[1], act[0],
               exp[13:11], exp[10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  initial begin
    logic [7:0] one_hot;
    logic [2:0] w;

    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;

    // Single request from ptr=0, released at the third GRANT cycle.
    add("single_grant1", 8'h10, 1'b0, 3'd4, 1'b1, 8'h10, 1'b1, 1'b0);
    add("single_grant2", 8'h10, 1'b0, 3'd4, 1'b1, 8'h10, 1'b1, 1'b0);
    add("single_grant3", 8'h10, 1'b0, 3'd4, 1'b1, 8'h10, 1'b1, 1'b0);
    add("single_gap",    8'h10, 1'b1, 3'd4, 1'b0, 8'h00, 1'b1, 1'b0);
    add("single_idle",   8'h00, 1'b0, 3'd4, 1'b0, 8'h00, 1'b0, 1'b0);

    // Fairness with everyone requesting: ptr is 5 now, so order 5,6,7,0..4,5.
    for (int k = 0; k < 9; k++) begin
      w       = 3'((5 + k) % 8);
      one_hot = 8'h01;
      one_hot = one_hot << w;
      add("rr_grant", 8'hFF, 1'b1, w, 1'b1, one_hot, 1'b1, 1'b0);
      add("rr_gap",   8'hFF, 1'b1, w, 1'b0, 8'h00,   1'b1, 1'b0);
      add("rr_idle",  8'hFF, 1'b1, w, 1'b0, 8'h00,   1'b0, 1'b0);
    end

    // Wrap-around from ptr=6: 0 wins, then 5; bit changes beside sel are ignored.
    add("wrap_grant0",   8'h21, 1'b0, 3'd0, 1'b1, 8'h01, 1'b1, 1'b0);
    add("wrap_gap",      8'h21, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0);
    add("wrap_idle",     8'h21, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    add("wrap_grant5",   8'h21, 1'b0, 3'd5, 1'b1, 8'h20, 1'b1, 1'b0);
    add("other_bits",    8'h7E, 1'b0, 3'd5, 1'b1, 8'h20, 1'b1, 1'b0);

    // Owner drops req together with done: single exit, no timeout.
    add("drop_and_done", 8'h01, 1'b1, 3'd5, 1'b0, 8'h00, 1'b1, 1'b0);
    add("drop_idle",     8'h00, 1'b0, 3'd5, 1'b0, 8'h00, 1'b0, 1'b0);

    // Request drop alone releases the grant (ptr 6 -> winner 3).
    add("reqdrop_grant", 8'h08, 1'b0, 3'd3, 1'b1, 8'h08, 1'b1, 1'b0);
    add("reqdrop_gap",   8'h00, 1'b0, 3'd3, 1'b0, 8'h00, 1'b1, 1'b0);
    add("reqdrop_idle",  8'h00, 1'b0, 3'd3, 1'b0, 8'h00, 1'b0, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // HOLD_MAX=4: en exactly 4 cycles, timeout in the GAP, then re-grant.
    for (int k = 0; k < 4; k++) add("to_grant", 8'h02, 1'b0, 3'd1, 1'b1, 8'h02, 1'b1, 1'b0);
    add("to_gap",  8'h02, 1'b0, 3'd1, 1'b0, 8'h00, 1'b1, 1'b1);
    add("to_idle", 8'h02, 1'b0, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) add("to_regrant", 8'h02, 1'b0, 3'd1, 1'b1, 8'h02, 1'b1, 1'b0);
    // done at the limit cycle: one exit, no timeout pulse.
    add("limit_and_done", 8'h02, 1'b1, 3'd1, 1'b0, 8'h00, 1'b1, 1'b0);
    add("limit_idle",     8'h00, 1'b0, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0);
`else
    // No hold limit: the grant survives well past HOLD_MAX.
    for (int k = 0; k < 55; k++) add("hold_long", 8'h02, 1'b0, 3'd1, 1'b1, 8'h02, 1'b1, 1'b0);
    add("hold_done", 8'h02, 1'b1, 3'd1, 1'b0, 8'h00, 1'b1, 1'b0);
    add("hold_idle", 8'h00, 1'b0, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0);
`endif

    #12;
    check("reset_state", got(), pack(3'd0, 1'b0, 8'h00, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.req  = vecs[i].req;
      bus.done = vecs[i].done;
      @(posedge clk);
      #1;
      check(vecs[i].tag, got(), vecs[i].exp);
    end

    // Asynchronous reset in the middle of a grant (ptr is 2 here).
    @(negedge clk);
    bus.req  = 8'h04;
    bus.done = 1'b0;
    @(posedge clk);
    #1;
    check("pre_reset_grant", got(), pack(3'd2, 1'b1, 8'h04, 1'b1, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", got(), pack(3'd0, 1'b0, 8'h00, 1'b0, 1'b0));
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = 8'h81;
    @(posedge clk);
    #1;
    // Scan restarts from ptr=0, so bit 0 wins over bit 7.
    check("post_reset_ptr0", got(), pack(3'd0, 1'b1, 8'h01, 1'b1, 1'b0));
    @(negedge clk);
    bus.req  = 8'h80;
    bus.done = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_gap", got(), pack(3'd0, 1'b0, 8'h00, 1'b1, 1'b0));
    @(negedge clk);
    bus.done = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_idle", got(), pack(3'd0, 1'b0, 8'h00, 1'b0, 1'b0));
    @(negedge clk);
    @(posedge clk);
    #1;
    check("post_reset_grant7", got(), pack(3'd7, 1'b1, 8'h80, 1'b1, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
